// File: rtl/picorv32_trace_pkg.sv
// Shared register map and bit positions for the PicoRV32 trace buffer.
// Firmware headers and benches are generated from / import these constants.
package picorv32_trace_pkg;

  localparam int TRACE_W = 36;
  localparam int DROPS_W = 16;

  // Word index decoded from wb_adr_i[4:2]
  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_STATUS  = 3'd1,
    REG_DATA_LO = 3'd2,
    REG_DATA_HI = 3'd3,
    REG_THRESH  = 3'd4,
    REG_DROPS   = 3'd5
  } reg_idx_e;

  localparam logic [7:0] OFS_CTRL    = {3'b000, REG_CTRL,    2'b00};
  localparam logic [7:0] OFS_STATUS  = {3'b000, REG_STATUS,  2'b00};
  localparam logic [7:0] OFS_DATA_LO = {3'b000, REG_DATA_LO, 2'b00};
  localparam logic [7:0] OFS_DATA_HI = {3'b000, REG_DATA_HI, 2'b00};
  localparam logic [7:0] OFS_THRESH  = {3'b000, REG_THRESH,  2'b00};
  localparam logic [7:0] OFS_DROPS   = {3'b000, REG_DROPS,   2'b00};

  localparam int CTRL_ENABLE       = 0;
  localparam int CTRL_CLEAR        = 1;
  localparam int CTRL_STOP_ON_FULL = 2;

  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_OVERFLOW = 18;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; storage is not reset.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LVL_W      = DEPTH_LOG2 + 1,
  parameter int W          = 36
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(2**DEPTH_LOG2);

  logic [W-1:0]          r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/picorv32_trace_buffer.sv
// CPU trace capture buffer with a Wishbone classic slave register interface.
// Register writes and DATA_LO pops land on the same edge that raises wb_ack_o.
module picorv32_trace_buffer
  import picorv32_trace_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int LVL_W      = DEPTH_LOG2 + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trace_valid_i,
  input  logic [TRACE_W-1:0] trace_data_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               irq_o
);

  localparam logic [LVL_W-1:0] DEPTH_M1 = LVL_W'(2**DEPTH_LOG2 - 1);

  logic               r_enable;
  logic               r_sof;
  logic               r_overflow;
  logic [DROPS_W-1:0] r_drops;
  logic [LVL_W-1:0]   r_thresh;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_irq;

  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic [2:0]         w_idx;
  logic               w_ctrl_wr;
  logic               w_clear;
  logic               w_pop;
  logic               w_pop_eff;
  logic               w_push;
  logic               w_drop;
  logic               w_fill;
  logic [TRACE_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb_we_i;
  assign w_rd      = w_req & ~wb_we_i;
  assign w_idx     = wb_adr_i[4:2];

  assign w_ctrl_wr = w_wr & (w_idx == REG_CTRL);
  assign w_clear   = w_ctrl_wr & wb_dat_i[CTRL_CLEAR];
  assign w_pop     = w_rd & (w_idx == REG_DATA_LO);
  assign w_pop_eff = w_pop & ~w_empty;
  assign w_push    = trace_valid_i & r_enable;

  // A flush wins over any same-cycle push, so neither drop nor fill can be counted then
  assign w_drop    = w_push & ~w_clear & w_full & ~w_pop_eff;
  assign w_fill    = w_push & ~w_clear & ~w_pop_eff & (w_level == DEPTH_M1);

  assign w_unused  = &{1'b0, wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  trace_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LVL_W      (LVL_W),
    .W          (TRACE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_clear),
    .i_data  (trace_data_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rdata[CTRL_ENABLE]       = r_enable;
        w_rdata[CTRL_STOP_ON_FULL] = r_sof;
      end
      REG_STATUS: begin
        w_rdata[LVL_W-1:0]    = w_level;
        w_rdata[STAT_EMPTY]    = w_empty;
        w_rdata[STAT_FULL]     = w_full;
        w_rdata[STAT_OVERFLOW] = r_overflow;
      end
      REG_DATA_LO: if (!w_empty) w_rdata = w_head[31:0];
      REG_DATA_HI: if (!w_empty) w_rdata[3:0] = w_head[35:32];
      REG_THRESH:  w_rdata[LVL_W-1:0] = r_thresh;
      REG_DROPS:   w_rdata[DROPS_W-1:0] = r_drops;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_enable   <= 1'b0;
      r_sof      <= 1'b0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
      r_thresh   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= wb_dat_i[CTRL_ENABLE];
        r_sof    <= wb_dat_i[CTRL_STOP_ON_FULL];
      end
      if (r_sof && w_fill) r_enable <= 1'b0;

      if (w_clear)
        r_overflow <= 1'b0;
      else if (w_drop)
        r_overflow <= 1'b1;
      else if (w_wr && (w_idx == REG_STATUS) && wb_dat_i[STAT_OVERFLOW])
        r_overflow <= 1'b0;

      if (w_clear)
        r_drops <= '0;
      else if (w_drop && (r_drops != {DROPS_W{1'b1}}))
        r_drops <= r_drops + DROPS_W'(1);

      if (w_wr && (w_idx == REG_THRESH)) r_thresh <= wb_dat_i[LVL_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      r_irq <= ((r_thresh != '0) && (w_level >= r_thresh)) || r_overflow;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_picorv32_trace_buffer.sv
// Directed bench for picorv32_trace_buffer with a 4-deep FIFO.
// Expected values are hand-computed constants.
module tb_picorv32_trace_buffer;
  import picorv32_trace_pkg::*;

  localparam int DL2 = 2;
  localparam int LW  = DL2 + 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        trace_valid_i = 1'b0;
  logic [35:0] trace_data_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd;

  picorv32_trace_buffer #(.DEPTH_LOG2(DL2), .LVL_W(LW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .trace_valid_i (trace_valid_i),
    .trace_data_i  (trace_data_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .irq_o         (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer; optionally strobes a trace word in the request cycle
  task automatic wb_xfer(input logic w, input logic [7:0] ofs, input logic [31:0] wdat,
                         input logic with_push, input logic [35:0] pdat,
                         output logic [31:0] rdat);
    logic got_ack;
    got_ack = 1'b0;
    rdat = '0;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
    wb_adr_i = {24'd0, ofs}; wb_dat_i = wdat;
    if (with_push) begin trace_valid_i = 1'b1; trace_data_i = pdat; end
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge clk_i); #1;
      trace_valid_i = 1'b0;
      if (wb_ack_o) begin got_ack = 1'b1; rdat = wb_dat_o; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("ack_seen", got_ack, 1);
    @(posedge clk_i); #1;
    check("ack_one_cycle", wb_ack_o, 0);
    check("dat_idle_zero", wb_dat_o, 0);
  endtask

  task automatic wb_wr(input logic [7:0] ofs, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_xfer(1'b1, ofs, wdat, 1'b0, 36'd0, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, ofs, 32'd0, 1'b0, 36'd0, v);
    check(tag, v, exp);
  endtask

  task automatic push1(input logic [35:0] d);
    @(posedge clk_i); #1;
    trace_valid_i = 1'b1; trace_data_i = d;
    @(posedge clk_i); #1;
    trace_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_irq", irq_o, 0);
    rst_i = 1'b0;
    rd_chk("status_reset", OFS_STATUS, 32'h0001_0000);

    // basic capture and FWFT readout
    wb_wr(OFS_CTRL, 32'h1);
    push1(36'h1_0000_0001);
    push1(36'h2_0000_0002);
    push1(36'h3_0000_0003);
    rd_chk("status_lvl3", OFS_STATUS, 32'h0000_0003);
    rd_chk("data_hi_1", OFS_DATA_HI, 32'h1);
    rd_chk("data_lo_1", OFS_DATA_LO, 32'h0000_0001);
    rd_chk("status_lvl2", OFS_STATUS, 32'h0000_0002);
    rd_chk("ctrl_rb", OFS_CTRL, 32'h1);
    rd_chk("data_hi_2", OFS_DATA_HI, 32'h2);
    rd_chk("data_lo_2", OFS_DATA_LO, 32'h0000_0002);
    rd_chk("data_lo_3", OFS_DATA_LO, 32'h0000_0003);
    rd_chk("status_empty", OFS_STATUS, 32'h0001_0000);

    // empty read and unmapped offset
    rd_chk("data_lo_empty", OFS_DATA_LO, 32'h0);
    rd_chk("status_still_empty", OFS_STATUS, 32'h0001_0000);
    wb_wr(8'h18, 32'hFFFF_FFFF);
    rd_chk("unmapped", 8'h18, 32'h0);

    // overflow: 6 pushes into 4 slots (write pointer wraps)
    for (int i = 0; i < 6; i++) push1(36'hA_0000_0010 + 36'(i));
    rd_chk("status_ovf", OFS_STATUS, 32'h0006_0004);
    rd_chk("drops_2", OFS_DROPS, 32'h2);
    check("irq_ovf", irq_o, 1);
    rd_chk("data_hi_a", OFS_DATA_HI, 32'hA);
    wb_wr(OFS_STATUS, 32'h0004_0000);
    rd_chk("status_ovf_clr", OFS_STATUS, 32'h0002_0004);
    check("irq_ovf_clr", irq_o, 0);

    // full FIFO: push coincident with pop
    wb_xfer(1'b0, OFS_DATA_LO, 32'd0, 1'b1, 36'hB_0000_0099, rd);
    check("pop_with_push", rd, 32'h0000_0010);
    rd_chk("status_full_keep", OFS_STATUS, 32'h0002_0004);
    rd_chk("drops_keep", OFS_DROPS, 32'h2);
    rd_chk("drain_11", OFS_DATA_LO, 32'h11);
    rd_chk("drain_12", OFS_DATA_LO, 32'h12);
    rd_chk("drain_13", OFS_DATA_LO, 32'h13);
    rd_chk("newest_hi", OFS_DATA_HI, 32'hB);
    rd_chk("newest_last", OFS_DATA_LO, 32'h99);
    rd_chk("status_drained", OFS_STATUS, 32'h0001_0000);

    // threshold interrupt
    wb_wr(OFS_THRESH, 32'hFFFF_FFFA);
    rd_chk("thresh_rb", OFS_THRESH, 32'h2);
    push1(36'hC_0000_0001);
    repeat (2) @(posedge clk_i);
    #1;
    check("irq_lvl1", irq_o, 0);
    push1(36'hC_0000_0002);
    @(posedge clk_i); #1;
    check("irq_lvl2", irq_o, 1);
    rd_chk("thr_pop", OFS_DATA_LO, 32'h1);
    check("irq_after_pop", irq_o, 0);
    rd_chk("thr_pop2", OFS_DATA_LO, 32'h2);
    wb_wr(OFS_THRESH, 32'h0);

    // clear during push
    push1(36'hD_0000_0001);
    push1(36'hD_0000_0002);
    rd_chk("status_pre_clr", OFS_STATUS, 32'h0000_0002);
    wb_xfer(1'b1, OFS_CTRL, 32'h3, 1'b1, 36'hE_0000_0001, rd);
    rd_chk("status_clr", OFS_STATUS, 32'h0001_0000);
    rd_chk("drops_clr", OFS_DROPS, 32'h0);
    rd_chk("ctrl_after_clr", OFS_CTRL, 32'h1);

    // stop_on_full
    wb_wr(OFS_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) push1(36'hF_0000_0020 + 36'(i));
    rd_chk("status_sof", OFS_STATUS, 32'h0002_0004);
    rd_chk("drops_sof", OFS_DROPS, 32'h0);
    rd_chk("ctrl_sof", OFS_CTRL, 32'h4);
    rd_chk("head_sof", OFS_DATA_HI, 32'hF);
    check("irq_sof", irq_o, 0);
    wb_wr(OFS_THRESH, 32'h1);
    check("irq_thr1", irq_o, 1);

    // reset during a pending read
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = {24'd0, OFS_DATA_LO};
    #3 rst_i = 1'b1;
    #1;
    check("rst_mid_ack", wb_ack_o, 0);
    check("rst_mid_dat", wb_dat_o, 0);
    check("rst_mid_irq", irq_o, 0);
    @(posedge clk_i); #1;
    check("rst_hold_ack", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_ack", wb_ack_o, 0);
    check("post_rst_irq", irq_o, 0);
    rd_chk("post_rst_status", OFS_STATUS, 32'h0001_0000);
    rd_chk("post_rst_ctrl", OFS_CTRL, 32'h0);
    rd_chk("post_rst_thresh", OFS_THRESH, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/picorv32_trace_buffer.md
PICORV32_TRACE_BUFFER -- requirements
Module: picorv32_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, giving FIFO depth 2**DEPTH_LOG2 (512) trace words.
REQ-002 SHALL have parameter LVL_W, default DEPTH_LOG2+1, giving level/threshold width.
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 trace_valid_i  input  1  CPU trace word strobe, one word per high cycle.
REQ-006 trace_data_i  input  36  CPU trace word.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave controls.
REQ-008 wb_adr_i  input  32  byte address; only bits [4:2] decoded.
REQ-009 wb_dat_i  input  32  write data; wb_sel_i  input  4  byte lanes, ignored (full-word access only).
REQ-010 wb_dat_o  output  32  read data; wb_ack_o  output  1  transfer acknowledge.
REQ-011 irq_o  output  1  level interrupt to CPU irq line.

Function
REQ-012 Register map SHALL be: 0x00 CTRL, 0x04 STATUS, 0x08 DATA_LO, 0x0C DATA_HI, 0x10 THRESH, 0x14 DROPS; other offsets read 0, writes ignored.
REQ-013 CTRL SHALL be: bit0 enable (RW), bit1 clear (write-1 pulse, reads 0), bit2 stop_on_full (RW).
REQ-014 STATUS SHALL be read-only except bit18: [LVL_W-1:0] level, bit16 empty, bit17 full, bit18 overflow sticky (write 1 clears).
REQ-015 Capture: on a rising edge with trace_valid_i=1 and enable=1, trace_data_i SHALL be pushed; level visible in STATUS on a read issued the following cycle.
REQ-016 Push while full without same-cycle pop SHALL drop the word, set overflow, increment DROPS (16-bit, saturating at 0xFFFF).
REQ-017 Push while full with same-cycle pop SHALL be accepted; level unchanged.
REQ-018 stop_on_full=1 SHALL clear enable in the cycle the FIFO becomes full.
REQ-019 FIFO SHALL be first-word-fall-through; DATA_HI SHALL return head[35:32] in bits [3:0], zero-extended, without popping.
REQ-020 Reading DATA_LO SHALL return head[31:0] and pop exactly once per transfer; when empty SHALL return 0 and not pop.
REQ-021 Simultaneous push and pop SHALL keep level constant; pointers wrap modulo 2**DEPTH_LOG2.
REQ-022 Wishbone: wb_ack_o SHALL assert one cycle after wb_cyc_i&wb_stb_i&~wb_ack_o, for exactly one cycle; wb_dat_o valid with ack, 0 otherwise.
REQ-023 Register writes and pops SHALL take effect on the ack cycle edge.
REQ-024 clear SHALL empty FIFO, zero DROPS, clear overflow in one cycle; a push in the same cycle SHALL be discarded.
REQ-025 irq_o SHALL be registered: 1 when (THRESH!=0 and level>=THRESH) or overflow=1.
REQ-026 THRESH SHALL be LVL_W bits RW; upper bits read 0.

Reset
REQ-027 While rst_i=1: level 0, pointers 0, CTRL 0, THRESH 0, DROPS 0, overflow 0, wb_ack_o 0, wb_dat_o 0, irq_o 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer without ack; no pop occurs.
REQ-029 FIFO memory contents SHALL NOT require reset.

Structure
REQ-030 Register offsets and CTRL/STATUS bit positions SHALL live in shared package/include picorv32_trace_pkg for firmware header generation and benches.
REQ-031 Storage SHALL be one sub-module trace_fifo (sync FWFT FIFO: push, pop, full, empty, level, flush).
REQ-032 Estimated size 150-300 lines RTL total.

Verification
REQ-033 Enable, 3 trace words 0x1_0000_0001..0x3_0000_0003 -> STATUS level=3; DATA_HI=0x1, DATA_LO=0x00000001, then level=2.
REQ-034 DEPTH_LOG2=2, 6 pushes, no reads -> level=4, full=1, overflow=1, DROPS=2, irq_o=1; write STATUS bit18 -> overflow=0.
REQ-035 Full FIFO, push coincident with DATA_LO pop -> level stays 4, DROPS unchanged, newest word last out.
REQ-036 THRESH=2, push 1 word -> irq_o=0; push 2nd -> irq_o=1 by next cycle; pop one -> irq_o=0.
REQ-037 Read DATA_LO when empty -> wb_dat_o=0, ack single cycle, level stays 0; CTRL clear during push -> level=0.
REQ-038 Assert rst_i during pending read -> no ack, all outputs 0, level 0 after release.
